// File: rtl/onehot_decoder.sv
// Decodes 3-bit priority-encoder codes into one-hot words and buffers them in a FIFO.
// Optional ONEHOT_DECODER_ACCUM_EN adds a sticky OR-mask of every popped word.
module onehot_decoder #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic       in_zero,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out,
`ifdef ONEHOT_DECODER_ACCUM_EN
    output logic [7:0] mask,
    input  logic       mask_clr,
`endif
    output logic [3:0] level
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0]  DEPTH_L = 4'(FIFO_DEPTH);

    typedef enum logic {S_EMPTY, S_ACTIVE} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [3:0]    r_level;
    logic [7:0]    r_out;
    state_t        r_state;

    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_word;
    logic [PW-1:0] w_rd_nxt;
    logic [3:0]    w_level_nxt;
    logic [7:0]    w_head_nxt;

    assign w_pop    = (r_state == S_ACTIVE) && out_ready;
    assign in_ready = !rst && ((r_level < DEPTH_L) || w_pop);
    assign w_push   = in_valid && in_ready;
    assign w_word   = in_zero ? 8'h00 : (8'b1 << in_code);
    assign w_rd_nxt = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;

    always_comb begin
        w_level_nxt = r_level;
        unique case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 4'd1;
            2'b01:   w_level_nxt = r_level - 4'd1;
            default: w_level_nxt = r_level;
        endcase
    end

    // The output register is loaded with the head as it will be after this edge,
    // taking the incoming word when it lands exactly at the new read slot.
    always_comb begin
        w_head_nxt = '0;
        if (w_level_nxt == 4'd0)
            w_head_nxt = '0;
        else if (w_push && (r_wr_ptr == w_rd_nxt))
            w_head_nxt = w_word;
        else
            w_head_nxt = r_mem[w_rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_out    <= '0;
            r_state  <= S_EMPTY;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_level  <= w_level_nxt;
            r_out    <= w_head_nxt;
            unique case (r_state)
                S_EMPTY:  if (w_push && !w_pop) r_state <= S_ACTIVE;
                S_ACTIVE: if (w_pop && !w_push && (r_level == 4'd1)) r_state <= S_EMPTY;
                default:  r_state <= S_EMPTY;
            endcase
        end
    end

    assign out_valid = (r_state == S_ACTIVE);
    assign out       = r_out;
    assign level     = r_level;

`ifdef ONEHOT_DECODER_ACCUM_EN
    logic [7:0] r_mask;

    always_ff @(posedge clk) begin
        if (rst || mask_clr)
            r_mask <= '0;
        else if (w_pop)
            r_mask <= r_mask | r_out;
    end

    assign mask = r_mask;
`endif

endmodule

// File: tb/tb_onehot_decoder.sv
// Directed self-checking bench for onehot_decoder (FIFO_DEPTH=2).
// Exercises accumulation checks too when ONEHOT_DECODER_ACCUM_EN is defined.
module tb_onehot_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       in_zero;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [3:0] level;
`ifdef ONEHOT_DECODER_ACCUM_EN
    logic [7:0] mask;
    logic       mask_clr;
`endif

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    onehot_decoder #(.FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
`ifdef ONEHOT_DECODER_ACCUM_EN
        .mask      (mask),
        .mask_clr  (mask_clr),
`endif
        .level     (level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven at +1, outputs sampled at +2.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = '0; in_zero = 1'b0; out_ready = 1'b0;
`ifdef ONEHOT_DECODER_ACCUM_EN
        mask_clr = 1'b0;
`endif
        #1;
        check("in_ready_in_rst", 32'(in_ready), 32'd0);
        step(); step();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'h00);
        check("rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single code 0 through an empty FIFO
        in_valid = 1'b1; in_code = 3'd0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        check("c0_out", 32'(out), 32'h01);
        check("c0_valid", 32'(out_valid), 32'd1);
        check("c0_level", 32'(level), 32'd1);
        step(); #1;
        check("c0_drain_valid", 32'(out_valid), 32'd0);
        check("c0_drain_out", 32'(out), 32'h00);
        check("c0_drain_level", 32'(level), 32'd0);

        // Code 7 then a zero code whose in_code must be ignored
        in_valid = 1'b1; in_code = 3'd7; in_zero = 1'b0;
        step();
        in_code = 3'd5; in_zero = 1'b1;
        #1;
        check("c7_out", 32'(out), 32'h80);
        step();
        in_valid = 1'b0; in_zero = 1'b0;
        #1;
        check("zero_out", 32'(out), 32'h00);
        check("zero_valid", 32'(out_valid), 32'd1);
        check("zero_level", 32'(level), 32'd1);
        step(); #1;
        check("zero_drain_level", 32'(level), 32'd0);

        // Back-pressure: three pushes into a depth-2 FIFO
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd2;
        step();
        in_code = 3'd3;
        step();
        in_code = 3'd5;
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_level", 32'(level), 32'd2);
        step(); #1;
        check("full_hold_out", 32'(out), 32'h04);
        check("full_hold_level", 32'(level), 32'd2);
        in_valid = 1'b0; out_ready = 1'b1;
        step(); #1;
        check("drain1_out", 32'(out), 32'h08);
        check("drain1_level", 32'(level), 32'd1);
        step(); #1;
        check("drain2_valid", 32'(out_valid), 32'd0);
        check("drain2_level", 32'(level), 32'd0);

        // Fill, then stream push+pop across pointer wrap
        out_ready = 1'b0; in_valid = 1'b1;
        in_code = 3'd0; exp_q.push_back(8'h01);
        step();
        in_code = 3'd1; exp_q.push_back(8'h02);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_code = 3'((i + 2) % 8);
            #1;
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_out", 32'(out), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            exp_q.push_back(8'b1 << ((i + 2) % 8));
            step();
            #1;
            check("stream_level", 32'(level), 32'd2);
        end
        check("stream_last_out", 32'(out), 32'(exp_q[0]));

        // Reset while full overrides same-cycle transfers
        rst = 1'b1;
        #1;
        check("rst_full_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_full_valid", 32'(out_valid), 32'd0);
        check("rst_full_out", 32'(out), 32'h00);
        check("rst_full_level", 32'(level), 32'd0);
        step(); #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_out", 32'(out), 32'h00);

`ifdef ONEHOT_DECODER_ACCUM_EN
        out_ready = 1'b1;
        foreach (exp_q[i]) ;
        in_valid = 1'b1;
        in_code = 3'd1; step();
        in_code = 3'd4; step();
        in_code = 3'd4; step();
        in_valid = 1'b0;
        step(); #1;
        check("mask_acc", 32'(mask), 32'h12);
        in_valid = 1'b1; in_code = 3'd2;
        step();
        in_valid = 1'b0; mask_clr = 1'b1;
        #1;
        check("mask_pre_clr_out", 32'(out), 32'h04);
        step();
        mask_clr = 1'b0;
        #1;
        check("mask_clr", 32'(mask), 32'h00);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
